// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared types for the LEGv8 MEM stage
package legv8_pkg;

  localparam int REGW = 5;

  typedef enum logic [1:0] {IDLE, ACCESS, RETIRE} mem_state_t;

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic MemRead;
    logic MemWrite;
    logic Branch;
  } mem_ctrl_t;

endpackage

// File: rtl/memory_access_if.sv
// rtl/memory_access_if.sv - req/ack data memory bus between MEM stage and data memory
interface memory_access_if #(parameter int N = 64) ();

  logic         dm_req;
  logic         dm_we;
  logic [N-1:0] dm_addr;
  logic [N-1:0] dm_wdata;
  logic         dm_ack;
  logic [N-1:0] dm_rdata;

  modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_ack, dm_rdata);
  modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_ack, dm_rdata);

endinterface

// File: rtl/memory_access_flopre.sv
// rtl/memory_access_flopre.sv - W-bit flop with async active-low reset and load enable
module flopre #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - LEGv8 MEM stage: EX/MEM register, branch resolve,
// variable-latency data memory handshake and one-cycle writeback hand-off
module memory_access #(
  parameter int N    = 64,
  parameter int REGW = legv8_pkg::REGW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_E,
  output logic            ready_M,
  input  logic            flush_M,
  input  logic            Branch_E,
  input  logic            MemRead_E,
  input  logic            MemWrite_E,
  input  logic            RegWrite_E,
  input  logic            MemtoReg_E,
  input  logic [REGW-1:0] writeReg_E,
  input  logic [N-1:0]    PCBranch_E,
  input  logic [N-1:0]    aluResult_E,
  input  logic [N-1:0]    writeData_E,
  input  logic            zero_E,
  output logic            PCSrc_M,
  output logic [N-1:0]    PCBranch_M,
  memory_access_if.master dm,
  output logic            misalign_M,
  output logic            valid_W,
  output logic            RegWrite_W,
  output logic            MemtoReg_W,
  output logic [REGW-1:0] writeReg_W,
  output logic [N-1:0]    aluResult_W,
  output logic [N-1:0]    readData_W
);

  import legv8_pkg::*;

  localparam int EXW = $bits(mem_ctrl_t) + 1 + REGW + 3 * N;

  mem_state_t      state, state_n;
  mem_ctrl_t       ctrl_E, ctrl_M;
  logic            zero_M;
  logic [REGW-1:0] writeReg_M;
  logic [N-1:0]    aluResult_M, writeData_M;
  logic [EXW-1:0]  exmem_q;
  logic            transfer, first_M, squash, rd_capture;

  assign ctrl_E = '{RegWrite: RegWrite_E, MemtoReg: MemtoReg_E, MemRead: MemRead_E,
                    MemWrite: MemWrite_E, Branch: Branch_E};

  flopre #(.W(EXW)) u_exmem (
    .clk   (clk),
    .reset (reset),
    .en    (transfer),
    .d     ({ctrl_E, zero_E, writeReg_E, PCBranch_E, aluResult_E, writeData_E}),
    .q     (exmem_q)
  );

  assign {ctrl_M, zero_M, writeReg_M, PCBranch_M, aluResult_M, writeData_M} = exmem_q;

  // Load data is zeroed on every transfer so non-loads retire with readData_W = 0.
  flopre #(.W(N)) u_memwb (
    .clk   (clk),
    .reset (reset),
    .en    (transfer | rd_capture),
    .d     (rd_capture ? dm.dm_rdata : '0),
    .q     (readData_W)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      first_M <= 1'b0;
      squash  <= 1'b0;
    end else begin
      state   <= state_n;
      first_M <= transfer;
      if (transfer)                         squash <= 1'b0;
      else if (flush_M && state != IDLE)    squash <= 1'b1;
    end
  end

  // ready_M is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    state_n    = state;
    ready_M    = reset && (state == IDLE);
    transfer   = valid_E && ready_M;
    dm.dm_req  = 1'b0;
    dm.dm_we   = 1'b0;
    valid_W    = 1'b0;
    rd_capture = 1'b0;
    case (state)
      IDLE: begin
        if (transfer) state_n = (MemRead_E || MemWrite_E) ? ACCESS : RETIRE;
      end
      ACCESS: begin
        dm.dm_req  = 1'b1;
        dm.dm_we   = ctrl_M.MemWrite;
        rd_capture = dm.dm_ack && ctrl_M.MemRead && !squash && !flush_M;
        if (dm.dm_ack) state_n = RETIRE;
      end
      RETIRE: begin
        valid_W = !squash && !flush_M;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign dm.dm_addr  = aluResult_M;
  assign dm.dm_wdata = writeData_M;

  assign PCSrc_M    = ctrl_M.Branch && zero_M && first_M && !squash;
  assign misalign_M = first_M && (ctrl_M.MemRead || ctrl_M.MemWrite) && (aluResult_M[2:0] != 3'b000);

  assign RegWrite_W  = ctrl_M.RegWrite;
  assign MemtoReg_W  = ctrl_M.MemtoReg;
  assign writeReg_W  = writeReg_M;
  assign aluResult_W = aluResult_M;

endmodule
